// File: rtl/pattern_controller.sv
// Step sequencer: plays a NUM_BEATS-step note pattern at a selectable tempo,
// with play/pause/stop transport, single-step edits and a one-step-per-cycle wipe.
module pattern_controller #(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int NUM_BEATS = 16,
    parameter int PERIOD    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         play_btn,
    input  logic                         stop_btn,
    input  logic                         clear_btn,
    input  logic [1:0]                   tempo_sel,
    input  logic                         edit_valid,
    output logic                         edit_ready,
    input  logic [$clog2(NUM_BEATS)-1:0] edit_step,
    input  logic [3:0]                   edit_note,
    output logic [NUM_BEATS*4-1:0]       beats,
    output logic [$clog2(NUM_BEATS)-1:0] beat_count,
    output logic                         beat_tick,
    output logic [3:0]                   note,
    output logic                         playing
);
    localparam int BW = $clog2(NUM_BEATS);
    localparam logic [31:0] BASE = 32'(PERIOD * (CLK_FREQ / NUM_BEATS));

    typedef enum logic [1:0] {STOPPED, PLAYING, PAUSED, CLEARING} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [BW-1:0]          beat_count_q, beat_count_d;
    logic [NUM_BEATS*4-1:0] beats_q, beats_d;
    logic [BW-1:0]          clr_idx_q, clr_idx_d;
    logic [3:0]             note_q, note_d;
    logic                   beat_tick_q, beat_tick_d;
    logic                   playing_q, playing_d;
    logic                   edit_ready_q, edit_ready_d;
    logic [31:0]            interval;
    logic                   step_due;

    assign interval = BASE >> tempo_sel;
    assign step_due = cnt_q >= interval - 32'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        beat_count_d = beat_count_q;
        beats_d      = beats_q;
        clr_idx_d    = clr_idx_q;
        beat_tick_d  = 1'b0;
        note_d       = (state_q == PLAYING) ? beats_q[{beat_count_q, 2'b00} +: 4] : 4'h0;

        // Edit handshake: a write happens on any edge where edit_valid && edit_ready;
        // edit_ready is low only while the wipe sweep owns the pattern.
        if (edit_valid && edit_ready_q) begin
            beats_d[{edit_step, 2'b00} +: 4] = edit_note;
        end

        case (state_q)
            STOPPED: begin
                if (play_btn) begin
                    state_d = PLAYING;
                end else if (clear_btn) begin
                    state_d   = CLEARING;
                    clr_idx_d = '0;
                end
            end
            PLAYING: begin
                if (stop_btn) begin
                    state_d      = STOPPED;
                    cnt_d        = '0;
                    beat_count_d = '0;
                end else if (play_btn) begin
                    // Pausing freezes the counter on this edge so resume continues mid-step.
                    state_d = PAUSED;
                end else if (step_due) begin
                    cnt_d        = '0;
                    beat_count_d = beat_count_q + 1'b1;
                    beat_tick_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            PAUSED: begin
                if (stop_btn) begin
                    state_d      = STOPPED;
                    cnt_d        = '0;
                    beat_count_d = '0;
                end else if (play_btn) begin
                    state_d = PLAYING;
                end
            end
            CLEARING: begin
                beats_d[{clr_idx_q, 2'b00} +: 4] = 4'h0;
                if (clr_idx_q == BW'(NUM_BEATS - 1)) begin
                    state_d = STOPPED;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: state_d = STOPPED;
        endcase

        playing_d    = (state_d == PLAYING);
        edit_ready_d = (state_d != CLEARING);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= STOPPED;
            cnt_q        <= '0;
            beat_count_q <= '0;
            beats_q      <= '0;
            clr_idx_q    <= '0;
            note_q       <= '0;
            beat_tick_q  <= 1'b0;
            playing_q    <= 1'b0;
            edit_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            beat_count_q <= beat_count_d;
            beats_q      <= beats_d;
            clr_idx_q    <= clr_idx_d;
            note_q       <= note_d;
            beat_tick_q  <= beat_tick_d;
            playing_q    <= playing_d;
            edit_ready_q <= edit_ready_d;
        end
    end

    assign beats      = beats_q;
    assign beat_count = beat_count_q;
    assign beat_tick  = beat_tick_q;
    assign note       = note_q;
    assign playing    = playing_q;
    assign edit_ready = edit_ready_q;
endmodule

// File: tb/tb_pattern_controller.sv
// Directed bench for pattern_controller with CLK_FREQ=64, NUM_BEATS=4, PERIOD=1 (BASE=16).
module tb_pattern_controller;
    logic        clk;
    logic        rst_n;
    logic        play_btn;
    logic        stop_btn;
    logic        clear_btn;
    logic [1:0]  tempo_sel;
    logic        edit_valid;
    logic        edit_ready;
    logic [1:0]  edit_step;
    logic [3:0]  edit_note;
    logic [15:0] beats;
    logic [1:0]  beat_count;
    logic        beat_tick;
    logic [3:0]  note;
    logic        playing;

    int n_checks = 0;
    int n_fail   = 0;

    pattern_controller #(.CLK_FREQ(64), .NUM_BEATS(4), .PERIOD(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play_btn   (play_btn),
        .stop_btn   (stop_btn),
        .clear_btn  (clear_btn),
        .tempo_sel  (tempo_sel),
        .edit_valid (edit_valid),
        .edit_ready (edit_ready),
        .edit_step  (edit_step),
        .edit_note  (edit_note),
        .beats      (beats),
        .beat_count (beat_count),
        .beat_tick  (beat_tick),
        .note       (note),
        .playing    (playing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          idle;
        logic        play;
        logic        stop;
        logic [1:0]  tempo;
        logic        ev;
        logic [1:0]  es;
        logic [3:0]  en;
        logic        exp_playing;
        logic [1:0]  exp_beat;
        logic        exp_tick;
        logic [3:0]  exp_note;
        logic [15:0] exp_beats;
    } vec_t;

    vec_t vecs[33];

    function automatic vec_t mk(int idle, logic play, logic stop, logic [1:0] tempo,
                                logic ev, logic [1:0] es, logic [3:0] en,
                                logic ep, logic [1:0] eb, logic et, logic [3:0] enote,
                                logic [15:0] ebeats);
        vec_t v;
        v.idle = idle; v.play = play; v.stop = stop; v.tempo = tempo;
        v.ev = ev; v.es = es; v.en = en;
        v.exp_playing = ep; v.exp_beat = eb; v.exp_tick = et; v.exp_note = enote;
        v.exp_beats = ebeats;
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, ".playing"},    32'(playing),    32'd0);
        check({tag, ".edit_ready"}, 32'(edit_ready), 32'd1);
        check({tag, ".beat_count"}, 32'(beat_count), 32'd0);
        check({tag, ".beat_tick"},  32'(beat_tick),  32'd0);
        check({tag, ".note"},       32'(note),       32'd0);
        check({tag, ".beats"},      32'(beats),      32'd0);
    endtask

    task automatic do_edit(logic [1:0] s, logic [3:0] n);
        edit_valid = 1'b1;
        edit_step  = s;
        edit_note  = n;
        cycle();
        edit_valid = 1'b0;
    endtask

    initial begin
        int ready_low;
        logic [15:0] exp_b;

        rst_n = 1'b0; play_btn = 1'b1; stop_btn = 1'b0; clear_btn = 1'b0;
        tempo_sel = 2'd0; edit_valid = 1'b1; edit_step = 2'd1; edit_note = 4'hF;

        // Outputs must sit at reset values for every cycle of reset, whatever the inputs do.
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_reset_vals($sformatf("reset%0d", i));
        end
        rst_n = 1'b1; play_btn = 1'b0; edit_valid = 1'b0;

        //            idle pl st tp ev es en    ply beat tk note beats
        vecs[0]  = mk(0,  0, 0, 0, 1, 0, 1,    0,  0,  0, 0, 16'h0001);
        vecs[1]  = mk(0,  0, 0, 0, 1, 1, 2,    0,  0,  0, 0, 16'h0021);
        vecs[2]  = mk(0,  0, 0, 0, 1, 2, 3,    0,  0,  0, 0, 16'h0321);
        vecs[3]  = mk(0,  0, 0, 0, 1, 3, 4,    0,  0,  0, 0, 16'h4321);
        vecs[4]  = mk(0,  1, 0, 0, 0, 0, 0,    1,  0,  0, 0, 16'h4321);
        vecs[5]  = mk(0,  0, 0, 0, 0, 0, 0,    1,  0,  0, 1, 16'h4321);
        vecs[6]  = mk(14, 0, 0, 0, 0, 0, 0,    1,  1,  1, 1, 16'h4321);
        vecs[7]  = mk(0,  0, 0, 0, 0, 0, 0,    1,  1,  0, 2, 16'h4321);
        vecs[8]  = mk(14, 0, 0, 0, 0, 0, 0,    1,  2,  1, 2, 16'h4321);
        vecs[9]  = mk(0,  0, 0, 0, 0, 0, 0,    1,  2,  0, 3, 16'h4321);
        vecs[10] = mk(14, 0, 0, 0, 0, 0, 0,    1,  3,  1, 3, 16'h4321);
        vecs[11] = mk(0,  0, 0, 0, 0, 0, 0,    1,  3,  0, 4, 16'h4321);
        vecs[12] = mk(14, 0, 0, 0, 0, 0, 0,    1,  0,  1, 4, 16'h4321);
        vecs[13] = mk(0,  0, 0, 0, 0, 0, 0,    1,  0,  0, 1, 16'h4321);
        vecs[14] = mk(9,  0, 0, 1, 0, 0, 0,    1,  1,  1, 1, 16'h4321);
        vecs[15] = mk(0,  0, 0, 1, 0, 0, 0,    1,  1,  0, 2, 16'h4321);
        vecs[16] = mk(6,  0, 0, 1, 0, 0, 0,    1,  2,  1, 2, 16'h4321);
        vecs[17] = mk(5,  1, 0, 1, 0, 0, 0,    0,  2,  0, 3, 16'h4321);
        vecs[18] = mk(0,  0, 0, 1, 0, 0, 0,    0,  2,  0, 0, 16'h4321);
        vecs[19] = mk(3,  1, 0, 1, 0, 0, 0,    1,  2,  0, 0, 16'h4321);
        vecs[20] = mk(0,  0, 0, 1, 0, 0, 0,    1,  2,  0, 3, 16'h4321);
        vecs[21] = mk(1,  0, 0, 1, 0, 0, 0,    1,  3,  1, 3, 16'h4321);
        vecs[22] = mk(7,  0, 0, 1, 0, 0, 0,    1,  0,  1, 4, 16'h4321);
        vecs[23] = mk(7,  0, 0, 1, 0, 0, 0,    1,  1,  1, 1, 16'h4321);
        vecs[24] = mk(7,  0, 0, 1, 0, 0, 0,    1,  2,  1, 2, 16'h4321);
        vecs[25] = mk(0,  1, 1, 1, 0, 0, 0,    0,  0,  0, 3, 16'h4321);
        vecs[26] = mk(0,  0, 0, 1, 0, 0, 0,    0,  0,  0, 0, 16'h4321);
        vecs[27] = mk(10, 0, 0, 1, 0, 0, 0,    0,  0,  0, 0, 16'h4321);
        vecs[28] = mk(0,  1, 0, 1, 0, 0, 0,    1,  0,  0, 0, 16'h4321);
        vecs[29] = mk(7,  0, 0, 1, 0, 0, 0,    1,  1,  1, 1, 16'h4321);
        vecs[30] = mk(0,  0, 0, 1, 1, 1, 7,    1,  1,  0, 2, 16'h4371);
        vecs[31] = mk(0,  0, 0, 1, 0, 0, 0,    1,  1,  0, 7, 16'h4371);
        vecs[32] = mk(0,  0, 1, 1, 0, 0, 0,    0,  0,  0, 7, 16'h4371);

        // Idle cycles keep the previous tempo; each vector's tempo applies from its own edge.
        for (int i = 0; i < 33; i++) begin
            play_btn = 1'b0; stop_btn = 1'b0; edit_valid = 1'b0;
            for (int k = 0; k < vecs[i].idle; k++) begin
                cycle();
                check($sformatf("v%0d.idle%0d.beat_tick", i, k), 32'(beat_tick), 32'd0);
            end
            play_btn   = vecs[i].play;
            stop_btn   = vecs[i].stop;
            tempo_sel  = vecs[i].tempo;
            edit_valid = vecs[i].ev;
            edit_step  = vecs[i].es;
            edit_note  = vecs[i].en;
            cycle();
            play_btn = 1'b0; stop_btn = 1'b0; edit_valid = 1'b0;
            check($sformatf("v%0d.playing", i),    32'(playing),    32'(vecs[i].exp_playing));
            check($sformatf("v%0d.edit_ready", i), 32'(edit_ready), 32'd1);
            check($sformatf("v%0d.beat_count", i), 32'(beat_count), 32'(vecs[i].exp_beat));
            check($sformatf("v%0d.beat_tick", i),  32'(beat_tick),  32'(vecs[i].exp_tick));
            check($sformatf("v%0d.note", i),       32'(note),       32'(vecs[i].exp_note));
            check($sformatf("v%0d.beats", i),      32'(beats),      32'(vecs[i].exp_beats));
        end

        // Full wipe of an all-0xF pattern, with a play_btn during the sweep.
        for (int s = 0; s < 4; s++) do_edit(2'(s), 4'hF);
        check("wipe.fill", 32'(beats), 32'h0000FFFF);
        ready_low = 0;
        clear_btn = 1'b1;
        cycle();
        clear_btn = 1'b0;
        if (edit_ready == 1'b0) ready_low++;
        check("wipe.c0.beats", 32'(beats), 32'h0000FFFF);
        for (int k = 1; k <= 4; k++) begin
            play_btn = (k == 2);
            cycle();
            play_btn = 1'b0;
            if (edit_ready == 1'b0) ready_low++;
            exp_b = 16'hFFFF << (4 * k);
            check($sformatf("wipe.c%0d.beats", k), 32'(beats), 32'(exp_b));
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (edit_ready == 1'b0) ready_low++;
            check($sformatf("wipe.after%0d.playing", k), 32'(playing), 32'd0);
            check($sformatf("wipe.after%0d.beat_tick", k), 32'(beat_tick), 32'd0);
        end
        check("wipe.ready_low_cycles", 32'(ready_low), 32'd4);
        check("wipe.edit_ready", 32'(edit_ready), 32'd1);

        // Edit and clear accepted on the same edge: the edit lands, then the sweep erases it.
        edit_valid = 1'b1; edit_step = 2'd2; edit_note = 4'hA; clear_btn = 1'b1;
        cycle();
        edit_valid = 1'b0; clear_btn = 1'b0;
        check("editclr.beats", 32'(beats), 32'h00000A00);
        check("editclr.edit_ready", 32'(edit_ready), 32'd0);
        repeat (4) cycle();
        check("editclr.done.beats", 32'(beats), 32'd0);
        check("editclr.done.edit_ready", 32'(edit_ready), 32'd1);
        check("editclr.done.playing", 32'(playing), 32'd0);

        // Reset for one cycle after two steps of a sweep have been wiped.
        for (int s = 0; s < 4; s++) do_edit(2'(s), 4'hF);
        clear_btn = 1'b1;
        cycle();
        clear_btn = 1'b0;
        cycle();
        cycle();
        check("rstclr.partial.beats", 32'(beats), 32'h0000FF00);
        check("rstclr.partial.edit_ready", 32'(edit_ready), 32'd0);
        rst_n = 1'b0; play_btn = 1'b1;
        cycle();
        rst_n = 1'b1; play_btn = 1'b0;
        check_reset_vals("rstclr.reset");
        cycle();
        check_reset_vals("rstclr.after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pattern_controller.md
PATTERN_CONTROLLER -- requirements
Module: pattern_controller

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 12_000_000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter NUM_BEATS, default 16, meaning the steps per pattern loop (power of two, at least 2).
REQ-003 The block SHALL have parameter PERIOD, default 4, meaning the loop length in seconds at tempo_sel=0.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port play_btn, input, 1 bit: one-cycle pulse that toggles play/pause.
REQ-007 The block SHALL have port stop_btn, input, 1 bit: one-cycle pulse that stops playback and rewinds to step 0.
REQ-008 The block SHALL have port clear_btn, input, 1 bit: one-cycle pulse that requests a pattern wipe.
REQ-009 The block SHALL have port tempo_sel, input, 2 bits: tempo multiplier of 2^tempo_sel.
REQ-010 The block SHALL have port edit_valid, input, 1 bit: edit request valid.
REQ-011 The block SHALL have port edit_ready, output, 1 bit: edit request can be accepted.
REQ-012 The block SHALL have port edit_step, input, $clog2(NUM_BEATS) bits: the step index to write.
REQ-013 The block SHALL have port edit_note, input, 4 bits: the note code to write, where 0 = rest.
REQ-014 The block SHALL have port beats, output, NUM_BEATS*4 bits: the pattern; step i is held in bits [i*4 +: 4].
REQ-015 The block SHALL have port beat_count, output, $clog2(NUM_BEATS) bits: the current step.
REQ-016 The block SHALL have port beat_tick, output, 1 bit: one-cycle pulse on each step advance.
REQ-017 The block SHALL have port note, output, 4 bits: the registered note for the pitch decoder.
REQ-018 The block SHALL have port playing, output, 1 bit: high only in state PLAYING.

Function
REQ-019 The block SHALL implement a state machine with states STOPPED, PLAYING, PAUSED and CLEARING.
REQ-020 The block SHALL define the base interval as BASE = PERIOD*(CLK_FREQ/NUM_BEATS), computed as a 32-bit integer.
REQ-021 The block SHALL use the active interval INTERVAL = BASE >> tempo_sel, re-evaluated every cycle.
REQ-022 The block SHALL use a 32-bit cycle counter that increments only in PLAYING.
REQ-023 When the counter is >= INTERVAL-1 in PLAYING, the block SHALL, on that same edge, load the counter with 0, advance beat_count (NUM_BEATS-1 wraps to 0) and pulse beat_tick for one cycle.
REQ-024 On a tempo change, the block SHALL apply the new interval immediately with no counter reset; if the counter already exceeds the new INTERVAL-1, the step SHALL advance on the next edge.
REQ-025 On play_btn, the block SHALL move STOPPED->PLAYING, PLAYING->PAUSED and PAUSED->PLAYING.
REQ-026 In PAUSED, the block SHALL hold both the counter and beat_count, so that resuming continues mid-step.
REQ-027 On stop_btn in PLAYING or PAUSED, the block SHALL enter STOPPED with the counter at 0 and beat_count at 0 on the next edge.
REQ-028 If stop_btn and play_btn arrive in the same cycle, stop SHALL take priority.
REQ-029 The block SHALL accept clear_btn only in STOPPED and ignore it in all other states.
REQ-030 In CLEARING, the block SHALL zero one step per cycle, from index 0 up to NUM_BEATS-1, then return to STOPPED, taking exactly NUM_BEATS cycles.
REQ-031 In CLEARING, the block SHALL ignore play_btn, stop_btn and clear_btn.
REQ-032 The block SHALL drive edit_ready = 0 in CLEARING and 1 in all other states.
REQ-033 An edit SHALL be accepted when edit_valid && edit_ready.
REQ-034 An accepted edit SHALL update beats[edit_step*4 +: 4] on that edge, visible on beats the next cycle.
REQ-035 Edits SHALL be allowed in STOPPED, PLAYING and PAUSED.
REQ-036 If an edit and clear_btn are accepted in the same STOPPED cycle, the edit SHALL be written, and the subsequent clear SHALL wipe it.
REQ-037 The note output SHALL be registered as beats[beat_count*4 +: 4] when in PLAYING and 0 otherwise.
REQ-038 The note output SHALL lag beat_count by exactly one cycle.
REQ-039 When an edit targets the current step while PLAYING, note SHALL show the new value one cycle after beats updates.
REQ-040 beat_tick SHALL never assert outside PLAYING.

Reset
REQ-041 When rst_n=0 at a clock edge, the block SHALL force state STOPPED, counter 0, beat_count 0, beats all 0, note 0, beat_tick 0, playing 0 and edit_ready 1.
REQ-042 Reset SHALL take priority over all inputs and SHALL abort CLEARING mid-sweep.
REQ-043 Outputs SHALL hold their reset values for the whole time rst_n=0.

Verification (bench parameters: CLK_FREQ=64, NUM_BEATS=4, PERIOD=1, giving BASE=16)
REQ-044 Stimulus: write steps 0..3 = 1,2,3,4, then play_btn, tempo_sel=0.
- Required response: beat_tick every 16 cycles.
- beat_count runs 0,1,2,3,0.
- note runs 1,2,3,4,1, each value one cycle after its beat_count.
REQ-045 Stimulus: PLAYING at counter=10, set tempo_sel=1 (INTERVAL=8).
- Required response: advance on the next edge, then every 8 cycles.
- Then play_btn at counter=5: PAUSED, note=0, beat_count held.
- Then play_btn again: the advance occurs 3 cycles later.
REQ-046 Stimulus: play_btn and stop_btn in the same cycle while PLAYING at beat_count=2.
- Required response: STOPPED, beat_count=0, playing=0, no beat_tick.
REQ-047 Stimulus: pattern all 0xF, STOPPED, clear_btn.
- Required response: edit_ready=0 for exactly 4 cycles, beats=0 afterwards, then STOPPED.
- play_btn pulsed during the sweep is ignored.
REQ-048 Stimulus: rst_n=0 for 1 cycle mid-CLEARING with 2 steps wiped.
- Required response: all outputs at reset values, beats=0, edit_ready=1 on the next cycle.
REQ-049 Stimulus: PLAYING at step 1, edit step 1 = 7.
- Required response: beats[7:4]=7 on the next cycle.
- note=7 one cycle after that.
